// File: rtl/lsu_mem_port_pkg.sv
// Shared definitions for the MEM-stage load/store port: access sizes, FSM states,
// the latched request record and the alignment rule.
package lsu_mem_port_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_MERGE = 2'd2
    } state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Size 3 is never legal; half needs addr[0]=0, word needs addr[1:0]=0.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        return (size == 2'd3) || (size == SZ_HALF && lane[0]) || (size == SZ_WORD && lane != 2'd0);
    endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Pipeline-side request/response bundle of the load/store port.
interface lsu_mem_port_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane handling: extract+extend of a RAM word for loads, and
// lane replacement of a RAM word for sub-word stores.
module lsu_lane_align
    import lsu_mem_port_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        sgn,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [4:0]  sh;
    logic [31:0] mask;
    logic [31:0] shifted;

    always_comb begin
        sh   = 5'd0;
        mask = 32'hFFFF_FFFF;
        case (size)
            SZ_BYTE: begin
                // Big-endian puts lane 0 in the top byte, so the shift runs from 3-lane.
                sh   = BIG_ENDIAN ? {~lane, 3'b000} : {lane, 3'b000};
                mask = 32'h0000_00FF;
            end
            SZ_HALF: begin
                sh   = BIG_ENDIAN ? {~lane[1], 4'b0000} : {lane[1], 4'b0000};
                mask = 32'h0000_FFFF;
            end
            default: ;
        endcase

        shifted = word >> sh;
        case (size)
            SZ_BYTE: load_data = {{24{sgn & shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_data = {{16{sgn & shifted[15]}}, shifted[15:0]};
            default: load_data = word;
        endcase

        merge_data = (word & ~(mask << sh)) | ((wdata & mask) << sh);
    end

endmodule

// File: rtl/lsu_mem_port.sv
// MEM-stage load/store adapter onto a word-wide, 1-cycle-latency synchronous RAM:
// FSM, latched request and registered response.
module lsu_mem_port
    import lsu_mem_port_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    lsu_mem_port_if.slave bus,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_in,
    output logic          mem_we,
    input  logic [31:0]   mem_out
);

    state_t      state, state_nx;
    req_t        cur, r;
    logic        accept, err;
    logic        resp_v_nx, resp_err_nx;
    logic [31:0] resp_rdata_nx;
    logic [31:0] load_data, merge_data;

    assign cur = '{we: bus.req_we, size: bus.req_size, sgn: bus.req_signed,
                   addr: bus.req_addr, wdata: bus.req_wdata};

    assign bus.req_ready = (state == ST_IDLE);
    assign accept        = bus.req_valid & bus.req_ready & ~rst;
    assign err           = misaligned(cur.size, cur.addr[1:0]);

    lsu_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
        .size       (r.size),
        .lane       (r.addr[1:0]),
        .sgn        (r.sgn),
        .word       (mem_out),
        .wdata      (r.wdata),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_comb begin
        state_nx      = state;
        mem_addr      = {2'b00, r.addr[31:2]};
        mem_we        = 1'b0;
        mem_in        = 32'd0;
        resp_v_nx     = 1'b0;
        resp_err_nx   = 1'b0;
        resp_rdata_nx = 32'd0;
        case (state)
            ST_IDLE: begin
                mem_addr = {2'b00, bus.req_addr[31:2]};
                if (accept) begin
                    if (err) begin
                        resp_v_nx   = 1'b1;
                        resp_err_nx = 1'b1;
                    end else if (cur.we && cur.size == SZ_WORD) begin
                        mem_we    = 1'b1;
                        mem_in    = cur.wdata;
                        resp_v_nx = 1'b1;
                    end else begin
                        state_nx = cur.we ? ST_MERGE : ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                resp_v_nx     = 1'b1;
                resp_rdata_nx = load_data;
                state_nx      = ST_IDLE;
            end
            ST_MERGE: begin
                // A reset landing here drops the write; the RAM keeps the old word.
                mem_we    = r.we & ~rst;
                mem_in    = rst ? 32'd0 : merge_data;
                resp_v_nx = 1'b1;
                state_nx  = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            r              <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 32'd0;
            bus.resp_err   <= 1'b0;
        end else begin
            state          <= state_nx;
            bus.resp_valid <= resp_v_nx;
            bus.resp_rdata <= resp_rdata_nx;
            bus.resp_err   <= resp_err_nx;
            if (accept) r <= cur;
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Randomised bench for lsu_mem_port: byte-addressed big-endian memory model with
// per-cycle response/write schedules, plus directed literal checks.
module tb_lsu_mem_port;
    import lsu_mem_port_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_mem_port_if bus();
    logic [31:0] mem_addr, mem_in, mem_out;
    logic        mem_we;

    lsu_mem_port #(.BIG_ENDIAN(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .mem_addr (mem_addr),
        .mem_in   (mem_in),
        .mem_we   (mem_we),
        .mem_out  (mem_out)
    );

    // Downstream RAM: 256 words, 1-cycle read latency.
    logic [31:0] ram [256];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[7:0]] <= mem_in;
        mem_out <= ram[mem_addr[7:0]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: byte-addressed memory, byte 4k+0 is the most significant of word k.
    logic [7:0] refb [1024];

    typedef struct { int due; logic [31:0] data; logic err; } rsp_t;
    typedef struct { int due; logic [31:0] addr; logic [31:0] data; } wr_t;
    rsp_t rq[$];
    wr_t  wq[$];

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] last_rdata = 32'd0;
    logic [31:0] last_err = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [9:0] a);
        logic [9:0] b;
        b = {a[9:2], 2'b00};
        return {refb[b], refb[b + 10'd1], refb[b + 10'd2], refb[b + 10'd3]};
    endfunction

    always @(negedge clk) begin
        bit rv, wv;
        rv = (rq.size() > 0) && (rq[0].due == cyc);
        chk("resp_valid", 32'(bus.resp_valid), 32'(rv));
        if (rv) begin
            chk("resp_rdata", bus.resp_rdata, rq[0].data);
            chk("resp_err", 32'(bus.resp_err), 32'(rq[0].err));
            last_rdata = bus.resp_rdata;
            last_err   = 32'(bus.resp_err);
            void'(rq.pop_front());
        end
        wv = (wq.size() > 0) && (wq[0].due == cyc);
        chk("mem_we", 32'(mem_we), 32'(wv));
        if (wv) begin
            chk("mem_addr", mem_addr, wq[0].addr);
            chk("mem_in", mem_in, wq[0].data);
            void'(wq.pop_front());
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Starts and ends at posedge+1. Waits for ready, presents the request for one
    // accepted cycle, records what the model says must follow, then scrambles req_*.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit abort = 1'b0);
        int n;
        logic [9:0]  a;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] v;
        bit          e;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.req_ready) chk("ready_timeout", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        a = addr[9:0];
        e = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
        if (!abort) begin
            if (e) begin
                rq.push_back('{cyc + 1, 32'd0, 1'b1});
            end else if (we) begin
                case (size)
                    2'd0: refb[a] = wdata[7:0];
                    2'd1: begin refb[a] = wdata[15:8]; refb[a + 10'd1] = wdata[7:0]; end
                    default: begin
                        refb[a] = wdata[31:24]; refb[a + 10'd1] = wdata[23:16];
                        refb[a + 10'd2] = wdata[15:8]; refb[a + 10'd3] = wdata[7:0];
                    end
                endcase
                if (size == 2'd2) begin
                    wq.push_back('{cyc, addr >> 2, wdata});
                    rq.push_back('{cyc + 1, 32'd0, 1'b0});
                end else begin
                    wq.push_back('{cyc + 1, addr >> 2, ref_word(a)});
                    rq.push_back('{cyc + 2, 32'd0, 1'b0});
                end
            end else begin
                case (size)
                    2'd0: begin b = refb[a]; v = sgn ? {{24{b[7]}}, b} : {24'd0, b}; end
                    2'd1: begin h = {refb[a], refb[a + 10'd1]}; v = sgn ? {{16{h[15]}}, h} : {16'd0, h}; end
                    default: v = ref_word(a);
                endcase
                rq.push_back('{cyc + 2, v, 1'b0});
            end
        end
        @(posedge clk); #1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'($urandom_range(0, 1));
        bus.req_size   = 2'($urandom_range(0, 3));
        bus.req_signed = 1'($urandom_range(0, 1));
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
        bus.req_signed = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        for (int i = 0; i < 1024; i++) refb[i] = 8'($urandom);
        refb[16] = 8'h88; refb[17] = 8'h99; refb[18] = 8'hAA; refb[19] = 8'hBB;
        for (int i = 0; i < 256; i++) ram[i] = ref_word(10'(i * 4));

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_in", mem_in, 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed loads against the preloaded word
        issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0); idle(2);
        chk("ld_word", last_rdata, 32'h8899AABB);
        chk("ld_word_err", last_err, 32'd0);
        issue(1'b0, SZ_BYTE, 1'b1, 32'h11, 32'd0); idle(2);
        chk("ld_byte_s", last_rdata, 32'hFFFFFF99);
        issue(1'b0, SZ_BYTE, 1'b0, 32'h11, 32'd0); idle(2);
        chk("ld_byte_u", last_rdata, 32'h00000099);
        issue(1'b0, SZ_HALF, 1'b1, 32'h12, 32'd0); idle(2);
        chk("ld_half_s", last_rdata, 32'hFFFFAABB);

        // Sub-word store then readback
        issue(1'b1, SZ_BYTE, 1'b0, 32'h13, 32'hDEADBE55); idle(2);
        issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'd0); idle(2);
        chk("rmw_readback", last_rdata, 32'h8899AA55);

        // Back-to-back word stores
        chk("b2b_ready0", 32'(bus.req_ready), 32'd1);
        issue(1'b1, SZ_WORD, 1'b0, 32'h20, 32'h1);
        chk("b2b_ready1", 32'(bus.req_ready), 32'd1);
        issue(1'b1, SZ_WORD, 1'b0, 32'h24, 32'h2);
        chk("b2b_ready2", 32'(bus.req_ready), 32'd1);
        issue(1'b1, SZ_WORD, 1'b0, 32'h28, 32'h3);
        idle(2);
        chk("ram8", ram[8], 32'h1);
        chk("ram9", ram[9], 32'h2);
        chk("ram10", ram[10], 32'h3);

        // Misaligned / illegal
        issue(1'b0, SZ_HALF, 1'b1, 32'h11, 32'd0); idle(1);
        chk("err_half", last_err, 32'd1);
        chk("err_half_rdata", last_rdata, 32'd0);
        issue(1'b1, SZ_WORD, 1'b0, 32'h12, 32'hCAFEF00D); idle(1);
        chk("err_word", last_err, 32'd1);
        issue(1'b0, 2'd3, 1'b0, 32'h10, 32'd0); idle(1);
        chk("err_size3", last_err, 32'd1);
        chk("err_keeps_word", ram[4], 32'h8899AA55);

        // Reset during MERGE drops the write and the ack
        issue(1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h77, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_ready", 32'(bus.req_ready), 32'd1);
        idle(2);
        chk("abort_word", ram[4], 32'h8899AA55);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            int gap, sr;
            logic [1:0]  sz;
            logic [31:0] ad;
            gap = $urandom_range(0, 2);
            if (gap > 0) idle(gap);
            sr = $urandom_range(0, 15);
            sz = (sr < 5) ? 2'd0 : (sr < 10) ? 2'd1 : (sr < 15) ? 2'd2 : 2'd3;
            ad = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) ad[0] = 1'b0;
                if (sz == 2'd2) ad[1:0] = 2'b00;
            end
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom);
        end

        idle(4);
        chk("resp_queue_drained", 32'(rq.size()), 32'd0);
        chk("write_queue_drained", 32'(wq.size()), 32'd0);
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 256; i++) if (ram[i] !== ref_word(10'(i * 4))) bad++;
            chk("ram_image", 32'(bad), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
